// File: rtl/rram_blwl_prog_seq.sv
// rram_blwl_prog_seq: two-phase BL/WL programming sequencer for the 6T-RRAM configuration cell.
// Optional define RRAM_PROG_SKIP_EN: skip requests whose target equals the last programmed value.
module rram_blwl_prog_seq #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic        prog_clock,
  input  logic        prog_reset,
  input  logic        req_valid,
  input  logic        req_data,
  output logic        req_ready,
  output logic [0:2]  bl,
  output logic [0:2]  wl,
  output logic        busy,
  output logic        done,
  output logic [15:0] prog_count
);

  typedef enum logic [2:0] {IDLE, PH1, GAP1, PH2, GAP2} state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP    = (GAP_CYCLES != 0);

  state_t     state;
  logic [7:0] cnt;
  logic       target;
  logic       phase_end;
  logic       finish;
  logic       skip_hit;
  logic [0:2] ph2_wl;

  assign phase_end = (cnt == '0);
  // Last timed state is GAP2, or PH2 when the gaps are compiled away.
  assign finish    = phase_end && ((state == GAP2) || (state == PH2 && !HAS_GAP));
  assign ph2_wl    = target ? 3'b010 : 3'b100;

`ifdef RRAM_PROG_SKIP_EN
  logic shadow_vld;
  logic shadow_val;

  assign skip_hit = shadow_vld && (shadow_val == req_data);

  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      shadow_vld <= 1'b0;
      shadow_val <= 1'b0;
    end else if (finish) begin
      shadow_vld <= 1'b1;
      shadow_val <= target;
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      target     <= 1'b0;
      bl         <= '0;
      wl         <= '0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      prog_count <= '0;
    end else begin
      done <= 1'b0;
      if (finish) begin
        state      <= IDLE;
        cnt        <= '0;
        bl         <= '0;
        wl         <= '0;
        busy       <= 1'b0;
        req_ready  <= 1'b1;
        done       <= 1'b1;
        prog_count <= prog_count + 16'd1;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              target <= req_data;
              if (skip_hit) begin
                done <= 1'b1;
              end else begin
                state     <= PH1;
                cnt       <= PULSE_LOAD;
                bl        <= req_data ? 3'b010 : 3'b100;
                wl        <= 3'b001;
                busy      <= 1'b1;
                req_ready <= 1'b0;
              end
            end
          end
          PH1: begin
            if (!phase_end) begin
              cnt <= cnt - 8'd1;
            end else if (HAS_GAP) begin
              state <= GAP1;
              cnt   <= GAP_LOAD;
              bl    <= '0;
              wl    <= '0;
            end else begin
              state <= PH2;
              cnt   <= PULSE_LOAD;
              bl    <= 3'b001;
              wl    <= ph2_wl;
            end
          end
          GAP1: begin
            if (!phase_end) begin
              cnt <= cnt - 8'd1;
            end else begin
              state <= PH2;
              cnt   <= PULSE_LOAD;
              bl    <= 3'b001;
              wl    <= ph2_wl;
            end
          end
          PH2: begin
            if (!phase_end) begin
              cnt <= cnt - 8'd1;
            end else begin
              state <= GAP2;
              cnt   <= GAP_LOAD;
              bl    <= '0;
              wl    <= '0;
            end
          end
          GAP2: begin
            cnt <= cnt - 8'd1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rram_blwl_prog_seq.sv
// Scoreboard bench for rram_blwl_prog_seq: two instances (P=2/G=1 and P=1/G=0) checked every cycle
// against a transaction-level model of the programming waveform.
module tb_rram_blwl_prog_seq;

  localparam int P0 = 2;
  localparam int G0 = 1;
  localparam int P1 = 1;
  localparam int G1 = 0;

  logic        prog_clock = 1'b0;
  logic        prog_reset;
  logic        rv  [2];
  logic        rd  [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [0:2]  bl  [2];
  logic [0:2]  wl  [2];
  logic [15:0] pc  [2];

  always #5 prog_clock = ~prog_clock;

  rram_blwl_prog_seq #(.PULSE_CYCLES(P0), .GAP_CYCLES(G0)) dut0 (
    .prog_clock(prog_clock), .prog_reset(prog_reset),
    .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rdy[0]),
    .bl(bl[0]), .wl(wl[0]), .busy(bsy[0]), .done(dn[0]), .prog_count(pc[0])
  );

  rram_blwl_prog_seq #(.PULSE_CYCLES(P1), .GAP_CYCLES(G1)) dut1 (
    .prog_clock(prog_clock), .prog_reset(prog_reset),
    .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rdy[1]),
    .bl(bl[1]), .wl(wl[1]), .busy(bsy[1]), .done(dn[1]), .prog_count(pc[1])
  );

  // k: edge index of the handshake; total: cycles of drive before the done cycle (0 when skipped)
  typedef struct {
    int k;
    bit data;
    int total;
  } txn_t;

  txn_t        q0[$];
  txn_t        q1[$];
  int unsigned m_count [2];
  bit          sh_vld  [2];
  bit          sh_val  [2];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          en = 1'b0;

  function automatic int pp(int i);
    return (i == 0) ? P0 : P1;
  endfunction

  function automatic int gg(int i);
    return (i == 0) ? G0 : G1;
  endfunction

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Expected {bl, wl} at position rel (1-based) of a sequence, from the phase timing table.
  function automatic logic [5:0] pattern(int i, bit data, int rel);
    logic [2:0] b;
    logic [2:0] w;
    int p;
    int g;
    p = pp(i);
    g = gg(i);
    b = 3'b000;
    w = 3'b000;
    if (rel >= 1 && rel <= p) begin
      b = data ? 3'b010 : 3'b100;
      w = 3'b001;
    end else if (rel > p + g && rel <= 2 * p + g) begin
      b = 3'b001;
      w = data ? 3'b010 : 3'b100;
    end
    return {b, w};
  endfunction

  task automatic check_inst(input int i);
    txn_t        h;
    bit          have;
    int          rel;
    logic [24:0] exp_v;
    logic [24:0] act_v;
    have = (qsize(i) > 0);
    if (have) begin
      if (i == 0) h = q0[0];
      else        h = q1[0];
    end
    exp_v = {6'b000000, 3'b010, 16'(m_count[i])};
    if (have) begin
      rel = cyc + 1 - h.k;
      if (rel <= h.total) begin
        exp_v = {pattern(i, h.data, rel), 3'b100, 16'(m_count[i])};
      end else if (rel == h.total + 1) begin
        if (h.total > 0) begin
          m_count[i] = m_count[i] + 1;
          sh_vld[i]  = 1'b1;
          sh_val[i]  = h.data;
        end
        exp_v = {6'b000000, 3'b011, 16'(m_count[i])};
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
    act_v = {bl[i], wl[i], bsy[i], rdy[i], dn[i], pc[i]};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL dut%0d_outputs edge %0d: got bl=%b wl=%b busy=%b ready=%b done=%b count=%0d, expected bl=%b wl=%b busy=%b ready=%b done=%b count=%0d",
               i, cyc, act_v[24:22], act_v[21:19], act_v[18], act_v[17], act_v[16], act_v[15:0],
               exp_v[24:22], exp_v[21:19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
    end
  endtask

  always @(posedge prog_clock) begin
    cyc = cyc + 1;
    #1;
    if (en) begin
      check_inst(0);
      check_inst(1);
    end
  end

  task automatic offer(input int i, input bit v, input bit d);
    txn_t t;
    if (v && qsize(i) == 0) begin
      t.k     = cyc + 1;
      t.data  = d;
      t.total = 2 * pp(i) + 2 * gg(i);
`ifdef RRAM_PROG_SKIP_EN
      if (sh_vld[i] && sh_val[i] == d) t.total = 0;
`endif
      if (i == 0) q0.push_back(t);
      else        q1.push_back(t);
    end
  endtask

  task automatic step(input bit v0, input bit d0, input bit v1, input bit d1, input bit rst);
    @(negedge prog_clock);
    prog_reset = rst;
    rv[0] = v0;
    rd[0] = d0;
    rv[1] = v1;
    rd[1] = d1;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_count = '{0, 0};
      sh_vld  = '{1'b0, 1'b0};
      sh_val  = '{1'b0, 1'b0};
    end else begin
      offer(0, v0, d0);
      offer(1, v1, d1);
    end
  endtask

  initial begin
    bit rst;
    prog_reset = 1'b1;
    rv = '{1'b0, 1'b0};
    rd = '{1'b0, 1'b0};
    m_count = '{0, 0};
    sh_vld  = '{1'b0, 1'b0};
    sh_val  = '{1'b0, 1'b0};
    en = 1'b1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // target 0, then data toggled after acceptance
    step(1, 0, 1, 0, 0);
    repeat (8) step(0, 1, 0, 1, 0);
    // target 1
    step(1, 1, 1, 1, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    // valid held high with alternating data
    for (int n = 0; n < 30; n++) step(1, bit'(n % 2), 1, bit'((n + 1) % 2), 0);
    repeat (8) step(0, 0, 0, 0, 0);
    // same target twice
    step(1, 1, 1, 1, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    // reset landing in PH2 of dut0, with a request offered on the reset edge
    step(1, 0, 1, 1, 0);
    repeat (P0 + G0) step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    repeat (8) step(0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), rst);
    end
    repeat (12) step(0, 0, 0, 0, 0);

    @(negedge prog_clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rram_blwl_prog_seq.md
# rram_blwl_prog_seq

Programming sequencer for the 6T-RRAM SRAM configuration cell. It accepts one requested bit value at a time and drives the cell's 3-bit bit-line (`bl[0:2]`) and word-line (`wl[0:2]`) buses through the two-phase pulse sequence that writes `dout` to that value. It sits directly upstream of the cell (`sram6T_rram`), which consumes its `bl`/`wl` outputs; a configuration-chain controller feeds it requests.

## Interface
- `PULSE_CYCLES`, default 2: cycles each programming phase holds its BL/WL pattern. Legal range 1..255.
- `GAP_CYCLES`, default 1: idle cycles (`bl` = `wl` = 0) after each phase. Legal range 0..255.
- `prog_clock` in 1: programming clock; all state changes on its rising edge.
- `prog_reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_data` in 1: target `dout` value to program.
- `req_ready` out 1: sequencer can accept a request.
- `bl` out [0:2]: bit-line drive to the cell.
- `wl` out [0:2]: word-line drive to the cell.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse marking completion of an accepted request.
- `prog_count` out 16: number of completed programming sequences; wraps modulo 2^16.

## Operation
- FSM states: IDLE, PH1, GAP1, PH2, GAP2.
- IDLE: `req_ready`=1, `busy`=0, `bl`=`wl`=000. A handshake (`req_valid`&&`req_ready`) latches `req_data` and moves to PH1.
- PH1 patterns for the duration: target 0 → `bl`=100, `wl`=001; target 1 → `bl`=010, `wl`=001.
- PH2 patterns for the duration: target 0 → `bl`=001, `wl`=100; target 1 → `bl`=001, `wl`=010.
- GAP1 and GAP2: `bl`=`wl`=000. When `GAP_CYCLES`=0, both gap states are skipped: PH1→PH2, and PH2→IDLE.
- A single 8-bit down-counter times each state. It loads `PULSE_CYCLES-1` or `GAP_CYCLES-1` on state entry. The state advances when the counter reaches 0.
- On leaving the final state (GAP2, or PH2 when `GAP_CYCLES`=0), the FSM returns to IDLE and `prog_count` increments.
- `done` is asserted for exactly the first IDLE cycle after a sequence. A new request can be accepted in that same cycle.
- `busy` = (state != IDLE). `req_ready` = !`busy`.
- All outputs are registered. `bl` and `wl` are never nonzero outside PH1 and PH2. No two phases ever overlap.
- `req_valid` while busy is ignored. `req_data` changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, `bl`=000, `wl`=000, `busy`=0, `req_ready`=1, `done`=0, `prog_count`=0, counter 0.
- Handshake at edge k. PH1 drives cycles k+1..k+P, GAP1 k+P+1..k+P+G, PH2 k+P+G+1..k+2P+G, GAP2 to k+2P+2G. `done` fires at cycle k+2P+2G+1 (P=`PULSE_CYCLES`, G=`GAP_CYCLES`).
- Back-to-back requests: minimum spacing between handshakes is 2P+2G+1 cycles.
- Reset mid-sequence: from the next edge, `bl`/`wl`=000 and state is IDLE. No `done` is issued, and `prog_count` is unchanged from its reset value 0.
- Reset and `req_valid` asserted together: reset wins and the request is not accepted.

## Configuration
- `RRAM_PROG_SKIP_EN` defined: a shadow register (valid bit plus value, invalid after reset) records the last completed target.
  - A request whose `req_data` equals a valid shadow value is accepted but skips all phases.
  - `bl`/`wl` stay 000, `done` pulses at k+1, `req_ready` stays 1, and `prog_count` does not increment.
  - A reset mid-sequence invalidates the shadow.
- `RRAM_PROG_SKIP_EN` undefined: no shadow logic. Every accepted request runs the full sequence.

## Test plan
- Reset, then P=2, G=1, request 0 at k → `bl`/`wl`=100/001 at k+1..k+2, 000/000 at k+3, 001/100 at k+4..k+5, 000/000 at k+6. `done` at k+7; `prog_count`=1.
- Request 1 with P=2, G=1 → PH1 010/001, PH2 001/010, same cycle positions as above. `done` at k+7.
- G=0, P=1, request 0 → 100/001 at k+1, 001/100 at k+2, `done` at k+3. Second request accepted at k+3 runs immediately.
- `req_valid` held high through a sequence with alternating `req_data` → exactly one acceptance per 2P+2G+1 cycles, each latching `req_data` at its own handshake.
- `prog_reset` pulsed during PH2 → all outputs at reset values on the next cycle, no `done`, `prog_count`=0.
- With `RRAM_PROG_SKIP_EN`: request 1 twice → first runs the full sequence; second gives `done` at k+1 with `bl`/`wl`=000 throughout and `prog_count` remaining 1.
